// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory bridge: address map, access width codes
// and the UART transmitter state encoding.
package dmem_pkg;

  localparam logic [31:0] RamBase      = 32'h1001_0000;
  localparam logic [31:0] AddrLed      = 32'hFFFF_0000;
  localparam logic [31:0] AddrSeg      = 32'hFFFF_0004;
  localparam logic [31:0] AddrUartData = 32'hFFFF_0008;
  localparam logic [31:0] AddrUartStat = 32'hFFFF_000C;

  localparam logic [1:0] WidthByte    = 2'b00;
  localparam logic [1:0] WidthHalf    = 2'b01;
  localparam logic [1:0] WidthIllegal = 2'b10;
  localparam logic [1:0] WidthWord    = 2'b11;

  localparam int unsigned FifoDepth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// 8-entry TX byte FIFO feeding an 8N1 serializer with CLK_DIV clocks per bit.
module uart_tx_core
  import dmem_pkg::*;
#(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] byte_in,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [7:0]      fifo_q [FifoDepth];
  logic [2:0]      wr_ptr_q, rd_ptr_q;
  logic [3:0]      count_q;
  logic            push_ok, pop;
  tx_state_e       state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            bit_end;

  assign full    = (count_q == 4'd8);
  assign empty   = (count_q == 4'd0);
  assign busy    = (state_q != StIdle);
  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push_ok = push & ~full;
  assign bit_end = (baud_q == CntLast);

  // FIFO storage; contents need no reset since the count guards them
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= byte_in;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 3'd1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 3'd1;
      count_q <= count_q + {3'b000, push_ok} - {3'b000, pop};
    end
  end

  // Serializer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Serializer next state; the stop bit chains straight into the next start bit
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_q[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level: mark when idle or stopping, low for start, LSB of shifter for data
  always_comb begin
    tx = 1'b1;
    if (state_q == StStart)     tx = 1'b0;
    else if (state_q == StData) tx = shift_q[0];
  end

endmodule

// File: rtl/dmem_bridge.sv
// CPU data-memory bridge: word RAM with byte/half lanes, LED and 7-seg registers
// and an optional UART transmitter enabled by the DMEM_BRIDGE_UART_EN macro.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned CLK_DIV   = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        wea,
  input  logic        sign,
  input  logic [1:0]  width,
  output logic        err,
  output logic [15:0] led,
  output logic [31:0] seg_data,
  output logic        uart_tx
);

  localparam int unsigned IdxW     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RamBytes = 32'(4 * RAM_WORDS);

  logic [31:0]     mem [RAM_WORDS];
  logic [31:0]     ram_off, ram_word, ram_rdata;
  logic [15:0]     lane;
  logic [IdxW-1:0] ram_idx;
  logic            hit_ram, hit_led, hit_seg, hit_mmio, st;
  logic [15:0]     led_q;
  logic [31:0]     seg_q;

  assign ram_off = addr - RamBase;
  // Lower bound check keeps addresses below the base from wrapping into range.
  assign hit_ram = (addr >= RamBase) && (ram_off < RamBytes);
  assign ram_idx = ram_off[IdxW+1:2];
  assign hit_led = (addr == AddrLed);
  assign hit_seg = (addr == AddrSeg);

`ifdef DMEM_BRIDGE_UART_EN
  logic        hit_uart_data, hit_uart_stat;
  logic        tx_full, tx_empty, tx_busy, ovf_q;
  logic [31:0] uart_status;

  assign hit_uart_data = (addr == AddrUartData);
  assign hit_uart_stat = (addr == AddrUartStat);
  assign hit_mmio      = hit_led | hit_seg | hit_uart_data | hit_uart_stat;
  assign uart_status   = {28'h0, ovf_q, tx_busy, tx_empty, tx_full};

  uart_tx_core #(
    .CLK_DIV(CLK_DIV)
  ) u_uart_tx_core (
    .clk    (clk),
    .rst    (rst),
    .push   (st & hit_uart_data),
    .byte_in(data_in[7:0]),
    .full   (tx_full),
    .empty  (tx_empty),
    .busy   (tx_busy),
    .tx     (uart_tx)
  );

  // Sticky overflow flag: set by a dropped push, cleared by writing bit 3 of status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (st && hit_uart_data && tx_full) begin
      ovf_q <= 1'b1;
    end else if (st && hit_uart_stat && data_in[3]) begin
      ovf_q <= 1'b0;
    end
  end
`else
  assign hit_mmio = hit_led | hit_seg;
  assign uart_tx  = 1'b1;
`endif

  // Access fault decode
  always_comb begin
    err = 1'b0;
    if (!(hit_ram || hit_mmio))                     err = 1'b1;
    if (width == WidthIllegal)                      err = 1'b1;
    if (width == WidthHalf && addr[0])              err = 1'b1;
    if (width == WidthWord && addr[1:0] != 2'b00)   err = 1'b1;
    if (hit_mmio && width != WidthWord)             err = 1'b1;
  end

  assign st       = wea & ~err;
  assign ram_word = mem[ram_idx];
  assign lane     = 16'(ram_word >> {addr[1:0], 3'b000});

  // RAM load lane extraction and extension
  always_comb begin
    unique case (width)
      WidthByte: ram_rdata = {{24{sign & lane[7]}}, lane[7:0]};
      WidthHalf: ram_rdata = {{16{sign & lane[15]}}, lane[15:0]};
      default:   ram_rdata = ram_word;
    endcase
  end

  // Load data mux; faults and UART_DATA read as zero
  always_comb begin
    data_out = 32'h0;
    if (!err) begin
      if (hit_ram)      data_out = ram_rdata;
      else if (hit_led) data_out = {16'h0, led_q};
      else if (hit_seg) data_out = seg_q;
`ifdef DMEM_BRIDGE_UART_EN
      else if (hit_uart_stat) data_out = uart_status;
`endif
    end
  end

  // RAM stores write only the addressed lane; contents survive reset
  always_ff @(posedge clk) begin
    if (st && hit_ram) begin
      unique case (width)
        WidthByte: mem[ram_idx][{addr[1:0], 3'b000} +: 8]  <= data_in[7:0];
        WidthHalf: mem[ram_idx][{addr[1], 4'b0000} +: 16]  <= data_in[15:0];
        default:   mem[ram_idx]                            <= data_in;
      endcase
    end
  end

  // Board output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q <= 16'h0;
      seg_q <= 32'h0;
    end else if (st) begin
      if (hit_led) led_q <= data_in[15:0];
      if (hit_seg) seg_q <= data_in;
    end
  end

  assign led      = led_q;
  assign seg_data = seg_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: a per-cycle reference model built from the
// address map and frame timing, plus directed vectors with literal expectations.
module tb_dmem_bridge;

  localparam int unsigned RamWords = 64;
  localparam int unsigned ClkDiv   = 4;
  localparam logic [31:0] Base     = 32'h1001_0000;
  localparam logic [31:0] ALed     = 32'hFFFF_0000;
  localparam logic [31:0] ASeg     = 32'hFFFF_0004;
  localparam logic [31:0] AUd      = 32'hFFFF_0008;
  localparam logic [31:0] AUs      = 32'hFFFF_000C;
`ifdef DMEM_BRIDGE_UART_EN
  localparam bit UartEn = 1'b1;
`else
  localparam bit UartEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic        wea = 1'b0;
  logic        sign = 1'b0;
  logic [1:0]  width = 2'b11;
  logic [31:0] data_out;
  logic        err;
  logic [15:0] led;
  logic [31:0] seg_data;
  logic        uart_tx;

  int vectors = 0;
  int miscompares = 0;

  dmem_bridge #(
    .RAM_WORDS(RamWords),
    .CLK_DIV  (ClkDiv)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .wea     (wea),
    .sign    (sign),
    .width   (width),
    .err     (err),
    .led     (led),
    .seg_data(seg_data),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ram [RamWords];
  bit          m_valid [RamWords];
  logic [15:0] m_led;
  logic [31:0] m_seg;
  bit          m_ovf;
  logic [7:0]  m_fifo [$];
  bit          m_active;
  int          m_pos;
  logic [7:0]  m_byte;

  function automatic bit m_in_ram(input logic [31:0] a);
    return (a >= Base) && ((a - Base) < 32'(4 * RamWords));
  endfunction

  function automatic int m_nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic void m_read(input logic [31:0] a, input logic [1:0] w, input logic s,
                                 output bit e, output logic [31:0] d, output bit known);
    int n;
    logic [31:0] v;
    e = 1'b0;
    d = 32'h0;
    known = 1'b1;
    n = m_nbytes(w);
    if (w == 2'b10) e = 1'b1;
    else if ((a % 32'(n)) != 0) e = 1'b1;
    else if (m_in_ram(a)) begin
      known = m_valid[(a - Base) / 4];
      v = m_ram[(a - Base) / 4] >> (8 * (a % 4));
      if (n == 1)      d = (s && v[7])  ? {24'hFF_FFFF, v[7:0]}  : {24'h0, v[7:0]};
      else if (n == 2) d = (s && v[15]) ? {16'hFFFF, v[15:0]}    : {16'h0, v[15:0]};
      else             d = v;
    end
    else if (n != 4) e = 1'b1;
    else if (a == ALed) d = {16'h0, m_led};
    else if (a == ASeg) d = m_seg;
    else if (UartEn && a == AUd) d = 32'h0;
    else if (UartEn && a == AUs)
      d = {28'h0, m_ovf, m_active, (m_fifo.size() == 0), (m_fifo.size() == 8)};
    else e = 1'b1;
  endfunction

  function automatic logic m_tx();
    logic [9:0] f;
    int k;
    if (!m_active) return 1'b1;
    f = {1'b1, m_byte, 1'b0};
    k = m_pos / int'(ClkDiv);
    return f[k];
  endfunction

  task automatic m_reset();
    m_led = 16'h0;
    m_seg = 32'h0;
    m_ovf = 1'b0;
    m_fifo.delete();
    m_active = 1'b0;
    m_pos = 0;
  endtask

  // Effect of the coming clock edge, given the inputs now applied
  task automatic m_step();
    bit e, known;
    logic [31:0] d;
    int n, was, idx, ln;
    m_read(addr, width, sign, e, d, known);
    was = m_fifo.size();
    if (UartEn) begin
      if (m_active && m_pos < int'(10 * ClkDiv) - 1) m_pos++;
      else if (was > 0) begin
        m_byte = m_fifo.pop_front();
        m_active = 1'b1;
        m_pos = 0;
      end else m_active = 1'b0;
    end
    if (wea && !e) begin
      if (m_in_ram(addr)) begin
        n = m_nbytes(width);
        idx = int'((addr - Base) / 4);
        ln = int'(addr % 4);
        for (int b = 0; b < n; b++) m_ram[idx][8*(ln+b) +: 8] = data_in[8*b +: 8];
        if (n == 4) m_valid[idx] = 1'b1;
      end
      else if (addr == ALed) m_led = data_in[15:0];
      else if (addr == ASeg) m_seg = data_in;
      else if (addr == AUd) begin
        if (was == 8) m_ovf = 1'b1;
        else m_fifo.push_back(data_in[7:0]);
      end
      else if (addr == AUs) begin
        if (data_in[3]) m_ovf = 1'b0;
      end
    end
  endtask

  // Compare process: every negedge, check outputs then advance the model
  bit          c_e, c_known;
  logic [31:0] c_d;
  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!rst) m_reset();
      m_read(addr, width, sign, c_e, c_d, c_known);
      check("err", {31'h0, err}, {31'h0, c_e});
      if (c_known) check("data_out", data_out, c_d);
      check("led", {16'h0, led}, {16'h0, m_led});
      check("seg_data", seg_data, m_seg);
      check("uart_tx", {31'h0, uart_tx}, {31'h0, m_tx()});
      if (rst) m_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    addr = a; data_in = d; width = w; wea = 1'b1; sign = 1'b0;
    @(posedge clk); #1;
    wea = 1'b0; addr = 32'h0; width = 2'b11; data_in = 32'h0;
  endtask

  task automatic xfer(input string name, input logic [31:0] a, input logic [31:0] d,
                      input logic we, input logic s, input logic [1:0] w,
                      input logic [31:0] exp_d, input logic exp_e);
    addr = a; data_in = d; wea = we; sign = s; width = w;
    #2;
    check({name, ".data"}, data_out, exp_d);
    check({name, ".err"}, {31'h0, err}, {31'h0, exp_e});
    @(posedge clk); #1;
    wea = 1'b0; addr = 32'h0; sign = 1'b0; width = 2'b11; data_in = 32'h0;
  endtask

  bit exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst.led", {16'h0, led}, 32'h0);
    check("rst.seg", seg_data, 32'h0);
    check("rst.tx", {31'h0, uart_tx}, 32'h1);
    rst = 1'b1;
    for (int i = 0; i < int'(RamWords); i++) store(Base + 32'(4 * i), 32'h0, 2'b11);

    // RAM lanes
    store(Base, 32'h8899_AABB, 2'b11);
    xfer("lb+3",  Base + 3, 0, 0, 1, 2'b00, 32'hFFFF_FF88, 0);
    xfer("lbu+0", Base,     0, 0, 0, 2'b00, 32'h0000_00BB, 0);
    xfer("lh+2",  Base + 2, 0, 0, 1, 2'b01, 32'hFFFF_8899, 0);
    xfer("lhu+2", Base + 2, 0, 0, 0, 2'b01, 32'h0000_8899, 0);
    xfer("lb+1",  Base + 1, 0, 0, 1, 2'b00, 32'hFFFF_FFAA, 0);
    store(Base + 1, 32'h55, 2'b00);
    xfer("sb_lw", Base, 0, 0, 0, 2'b11, 32'h8899_55BB, 0);
    store(Base + 4, 32'h1122_3344, 2'b11);
    store(Base + 6, 32'h0000_BEEF, 2'b01);
    xfer("sh_lw", Base + 4, 0, 0, 0, 2'b11, 32'hBEEF_3344, 0);

    // Faults
    xfer("lw_mis",   Base + 2,     0, 0, 0, 2'b11, 32'h0, 1);
    xfer("sh_mis",   Base + 3,     32'h0000_DEAD, 1, 0, 2'b01, 32'h0, 1);
    xfer("lw_unmap", 32'h2000_0000, 0, 0, 0, 2'b11, 32'h0, 1);
    xfer("w10_st",   Base,         32'hFFFF_FFFF, 1, 0, 2'b10, 32'h0, 1);
    xfer("lw_kept",  Base,         0, 0, 0, 2'b11, 32'h8899_55BB, 0);
    xfer("lw_end",   Base + 32'(4 * RamWords), 0, 0, 0, 2'b11, 32'h0, 1);
    xfer("lw_last",  Base + 32'(4 * (RamWords - 1)), 0, 0, 0, 2'b11, 32'h0, 0);
    xfer("lw_below", Base - 4,     0, 0, 0, 2'b11, 32'h0, 1);

    // LED / SEG
    store(ALed, 32'h1234_ABCD, 2'b11);
    check("led_out", {16'h0, led}, 32'h0000_ABCD);
    xfer("led_rd",   ALed, 0, 0, 0, 2'b11, 32'h0000_ABCD, 0);
    store(ASeg, 32'hCAFE_F00D, 2'b11);
    xfer("seg_rd",   ASeg, 0, 0, 0, 2'b11, 32'hCAFE_F00D, 0);
    xfer("led_lb",   ALed, 0, 0, 0, 2'b00, 32'h0, 1);
    xfer("seg_sh",   ASeg, 32'h1111, 1, 0, 2'b01, 32'h0, 1);
    xfer("seg_kept", ASeg, 0, 0, 0, 2'b11, 32'hCAFE_F00D, 0);
    xfer("mmio_gap", 32'hFFFF_0010, 0, 0, 0, 2'b11, 32'h0, 1);

`ifdef DMEM_BRIDGE_UART_EN
    xfer("ud_rd",     AUd, 0, 0, 0, 2'b11, 32'h0, 0);
    xfer("stat_idle", AUs, 0, 0, 0, 2'b11, 32'h2, 0);
    xfer("ud_lb",     AUd, 0, 0, 0, 2'b00, 32'h0, 1);
    store(AUd, 32'h0000_00A5, 2'b11);
    addr = AUs;
    #2;
    check("frame.pre_tx", {31'h0, uart_tx}, 32'h1);
    for (int k = 0; k < int'(10 * ClkDiv); k++) begin
      @(posedge clk); #2;
      check("frame.tx", {31'h0, uart_tx}, {31'h0, exp_bits[k / int'(ClkDiv)]});
      check("frame.stat", data_out, 32'h6);
    end
    @(posedge clk); #2;
    check("frame.end_tx", {31'h0, uart_tx}, 32'h1);
    check("frame.end_stat", data_out, 32'h2);
    @(posedge clk); #1;
    addr = 32'h0;

    // Overflow: first byte is popped, eight fill the FIFO, the tenth is dropped
    for (int i = 0; i < 10; i++) store(AUd, 32'h30 + 32'(i), 2'b11);
    xfer("ovf_stat",  AUs, 0, 0, 0, 2'b11, 32'hD, 0);
    store(AUs, 32'hFFFF_FFF7, 2'b11);
    xfer("ovf_keep",  AUs, 0, 0, 0, 2'b11, 32'hD, 0);
    store(AUs, 32'h0000_0008, 2'b11);
    xfer("ovf_clear", AUs, 0, 0, 0, 2'b11, 32'h5, 0);
    repeat (6) @(posedge clk);
    #1;
`else
    xfer("ud_unmap", AUd, 0, 0, 0, 2'b11, 32'h0, 1);
    xfer("us_unmap", AUs, 0, 0, 0, 2'b11, 32'h0, 1);
    xfer("ud_st",    AUd, 32'hA5, 1, 0, 2'b11, 32'h0, 1);
    check("tx_tied", {31'h0, uart_tx}, 32'h1);
`endif

    // Reset in the middle of a frame
    addr = AUs;
    rst = 1'b0;
    #1;
    check("midrst.tx", {31'h0, uart_tx}, 32'h1);
    check("midrst.led", {16'h0, led}, 32'h0);
    check("midrst.seg", seg_data, 32'h0);
`ifdef DMEM_BRIDGE_UART_EN
    check("midrst.stat", data_out, 32'h2);
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    addr = 32'h0;
    repeat (50) @(posedge clk);
    #1;
    check("post.tx", {31'h0, uart_tx}, 32'h1);
`ifdef DMEM_BRIDGE_UART_EN
    xfer("post.stat", AUs, 0, 0, 0, 2'b11, 32'h2, 0);
`endif
    xfer("post.ram", Base, 0, 0, 0, 2'b11, 32'h8899_55BB, 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
